// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with round-robin arbitration,
// optional packet lock and a registered one-beat output stage.
module stream_mux_rr #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned N_IN         = 4,
  parameter int unsigned LOCK_ON_LAST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN*WIDTH-1:0]     in_data,
  input  logic [N_IN-1:0]           in_valid,
  input  logic [N_IN-1:0]           in_last,
  output logic [N_IN-1:0]           in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [$clog2(N_IN)-1:0]   out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned SEL_W = $clog2(N_IN);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  logic [N_IN-1:0]  grant_c;
  logic [SEL_W-1:0] gnt_idx_c;
  logic             gnt_found_c;
  logic [SEL_W-1:0] cand_c;
  logic             can_load_c;
  logic             accept_c;
  logic [WIDTH-1:0] sel_data_c;
  logic             sel_last_c;

  // Channel index base+off, wrapped modulo N_IN (N_IN need not be a power of two).
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] base,
                                                 input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_IN) sum = sum - N_IN;
    return SEL_W'(sum);
  endfunction

  // Grant: the locked channel unconditionally, else first valid from ptr.
  always_comb begin
    grant_c     = '0;
    gnt_idx_c   = '0;
    gnt_found_c = 1'b0;
    cand_c      = '0;
    if (lock_q) begin
      gnt_idx_c   = lock_ch_q;
      gnt_found_c = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        cand_c = wrap_inc(ptr_q, k);
        if (!gnt_found_c && in_valid[cand_c]) begin
          gnt_idx_c   = cand_c;
          gnt_found_c = 1'b1;
        end
      end
    end
    if (gnt_found_c) grant_c[gnt_idx_c] = 1'b1;
  end

  assign can_load_c = !out_valid_q || out_ready;
  assign in_ready   = (rst || !can_load_c) ? '0 : grant_c;
  assign accept_c   = |(in_valid & in_ready);

  always_comb begin
    sel_data_c = '0;
    sel_last_c = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (gnt_idx_c == SEL_W'(i)) begin
        sel_data_c = in_data[i*WIDTH +: WIDTH];
        sel_last_c = in_last[i];
      end
    end
  end

  // Next state: load on accept, drain when the held beat is taken.
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (accept_c) begin
      out_data_d  = sel_data_c;
      out_last_d  = sel_last_c;
      out_sel_d   = gnt_idx_c;
      out_valid_d = 1'b1;
      if (LOCK_ON_LAST == 0 || sel_last_c) begin
        ptr_d  = wrap_inc(gnt_idx_c, 1);
        lock_d = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_idx_c;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and scoreboard checks for stream_mux_rr: a 4-input instance for
// reset/fairness/backpressure/lock, a 3-input instance for wrap and random traffic.
module tb_stream_mux_rr;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst4, out_ready4, out_last4, out_valid4;
  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_last4, in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_sel4;

  logic        rst3, out_ready3, out_last3, out_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;

  stream_mux_rr #(.WIDTH(8), .N_IN(4), .LOCK_ON_LAST(1)) dut4 (
    .clk(clk), .rst(rst4), .in_data(in_data4), .in_valid(in_valid4),
    .in_last(in_last4), .in_ready(in_ready4), .out_data(out_data4),
    .out_last(out_last4), .out_sel(out_sel4), .out_valid(out_valid4),
    .out_ready(out_ready4));

  stream_mux_rr #(.WIDTH(8), .N_IN(3), .LOCK_ON_LAST(1)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
    .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
    .out_last(out_last3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; in_valid4 = 4'b1111; in_last4 = 4'b1111;
    in_data4 = 32'h44332211; out_ready4 = 1'b1;
    cyc(); cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, out_last4} !== {1'b0, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%h s=%0d l=%b, want v=0 d=00 s=0 l=0",
               out_valid4, out_data4, out_sel4, out_last4);
    end
    n_checks++;
    if (in_ready4 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", in_ready4);
    end
    rst4 = 1'b0;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0001) begin
      n_fail++; $display("FAIL first_grant: got %b want 0001", in_ready4);
    end
    in_valid4 = 4'b0000;
    cyc();
  endtask

  task automatic test_single();
    in_valid4 = 4'b0100; in_last4 = 4'b0100; in_data4[23:16] = 8'h33;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", in_ready4);
    end
    cyc();
    in_valid4 = 4'b0000;
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, out_last4} !== {1'b1, 8'h33, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL single_out: got v=%b d=%h s=%0d l=%b, want v=1 d=33 s=2 l=1",
               out_valid4, out_data4, out_sel4, out_last4);
    end
    cyc();
  endtask

  task automatic test_fairness_backpressure();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst4 = 1'b1; in_valid4 = 4'b0000; cyc(); rst4 = 1'b0;
    in_data4 = 32'h44332211; in_last4 = 4'b1111; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cyc();
      n_checks++;
      if ({out_valid4, out_data4, out_sel4} !== {1'b1, exp_d[b % 4], 2'(b % 4)}) begin
        n_fail++;
        $display("FAIL fair_beat%0d: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d",
                 b, out_valid4, out_data4, out_sel4, exp_d[b % 4], b % 4);
      end
      if (b == 1) begin
        out_ready4 = 1'b0;
        for (int h = 0; h < 3; h++) begin
          #1;
          n_checks++;
          if ({out_valid4, out_data4, in_ready4} !== {1'b1, 8'h22, 4'b0000}) begin
            n_fail++;
            $display("FAIL backpressure%0d: got v=%b d=%h rdy=%b, want v=1 d=22 rdy=0000",
                     h, out_valid4, out_data4, in_ready4);
          end
          cyc();
        end
        out_ready4 = 1'b1;
      end
    end
    in_valid4 = 4'b0000;
    cyc();
  endtask

  task automatic test_packet_lock();
    out_ready4 = 1'b1; in_last4 = 4'b0101;
    in_data4 = {8'h00, 8'hC2, 8'hA1, 8'hC0}; in_valid4 = 4'b0111;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0001) begin
      n_fail++; $display("FAIL lock_pre_ready: got %b want 0001", in_ready4);
    end
    cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, in_ready4} !== {1'b1, 8'hC0, 2'd0, 4'b0010}) begin
      n_fail++;
      $display("FAIL lock_c0: got v=%b d=%h s=%0d rdy=%b, want v=1 d=C0 s=0 rdy=0010",
               out_valid4, out_data4, out_sel4, in_ready4);
    end
    cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, out_last4} !== {1'b1, 8'hA1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_a1: got v=%b d=%h s=%0d l=%b, want v=1 d=A1 s=1 l=0",
               out_valid4, out_data4, out_sel4, out_last4);
    end
    in_valid4 = 4'b0101;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0010) begin
      n_fail++; $display("FAIL lock_idle_ready: got %b want 0010", in_ready4);
    end
    cyc();
    n_checks++;
    if (out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL lock_idle_out: got v=%b want v=0", out_valid4);
    end
    in_data4[15:8] = 8'hA2; in_valid4 = 4'b0111;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0010) begin
      n_fail++; $display("FAIL lock_a2_ready: got %b want 0010", in_ready4);
    end
    cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, out_last4} !== {1'b1, 8'hA2, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_a2: got v=%b d=%h s=%0d l=%b, want v=1 d=A2 s=1 l=0",
               out_valid4, out_data4, out_sel4, out_last4);
    end
    in_data4[15:8] = 8'hA3; in_last4 = 4'b0111;
    cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4, out_last4} !== {1'b1, 8'hA3, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_a3: got v=%b d=%h s=%0d l=%b, want v=1 d=A3 s=1 l=1",
               out_valid4, out_data4, out_sel4, out_last4);
    end
    in_valid4 = 4'b0101;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0100) begin
      n_fail++; $display("FAIL lock_after_ready: got %b want 0100", in_ready4);
    end
    cyc();
    n_checks++;
    if ({out_valid4, out_data4, out_sel4} !== {1'b1, 8'hC2, 2'd2}) begin
      n_fail++;
      $display("FAIL lock_after_c2: got v=%b d=%h s=%0d, want v=1 d=C2 s=2",
               out_valid4, out_data4, out_sel4);
    end
    in_valid4 = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_mid_packet();
    rst3 = 1'b1; out_ready3 = 1'b1; in_valid3 = 3'b000; in_last3 = 3'b000;
    in_data3 = {8'hC2, 8'hA1, 8'hC0};
    cyc(); rst3 = 1'b0;
    in_valid3 = 3'b010;
    cyc();
    n_checks++;
    if ({out_valid3, out_data3, out_sel3} !== {1'b1, 8'hA1, 2'd1}) begin
      n_fail++;
      $display("FAIL mid_a1: got v=%b d=%h s=%0d, want v=1 d=A1 s=1",
               out_valid3, out_data3, out_sel3);
    end
    in_data3[15:8] = 8'hA2;
    cyc();
    n_checks++;
    if ({out_valid3, out_data3, out_sel3} !== {1'b1, 8'hA2, 2'd1}) begin
      n_fail++;
      $display("FAIL mid_a2: got v=%b d=%h s=%0d, want v=1 d=A2 s=1",
               out_valid3, out_data3, out_sel3);
    end
    rst3 = 1'b1; in_valid3 = 3'b011;
    #1;
    n_checks++;
    if (in_ready3 !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_ready: got %b want 000", in_ready3);
    end
    cyc();
    n_checks++;
    if ({out_valid3, out_data3} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL mid_rst_out: got v=%b d=%h, want v=0 d=00", out_valid3, out_data3);
    end
    rst3 = 1'b0; in_last3 = 3'b111;
    #1;
    n_checks++;
    if (in_ready3 !== 3'b001) begin
      n_fail++; $display("FAIL mid_unlock_ready: got %b want 001", in_ready3);
    end
    cyc();
    n_checks++;
    if ({out_valid3, out_data3, out_sel3} !== {1'b1, 8'hC0, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_c0: got v=%b d=%h s=%0d, want v=1 d=C0 s=0",
               out_valid3, out_data3, out_sel3);
    end
    in_valid3 = 3'b101;
    #1;
    n_checks++;
    if (in_ready3 !== 3'b100) begin
      n_fail++; $display("FAIL wrap_pre_ready: got %b want 100", in_ready3);
    end
    cyc();
    n_checks++;
    if ({out_valid3, out_data3, out_sel3, in_ready3} !== {1'b1, 8'hC2, 2'd2, 3'b001}) begin
      n_fail++;
      $display("FAIL wrap_2_to_0: got v=%b d=%h s=%0d rdy=%b, want v=1 d=C2 s=2 rdy=001",
               out_valid3, out_data3, out_sel3, in_ready3);
    end
    in_valid3 = 3'b000;
    cyc();
  endtask

  task automatic test_random();
    logic       pend [3];
    logic [7:0] dat  [3];
    logic       lst  [3];
    logic [5:0] seqn [3];
    logic       m_ov, m_ol, m_lock, can, found, acc;
    logic [7:0] m_od;
    int         m_os, m_ptr, m_lch, g, c;
    logic [2:0] exp_rdy;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; dat[i] = 8'h00; lst[i] = 1'b0; seqn[i] = 6'd0;
    end
    m_ov = 1'b0; m_ol = 1'b0; m_od = 8'h00; m_os = 0; m_ptr = 0; m_lock = 1'b0; m_lch = 0;
    rst3 = 1'b1; in_valid3 = 3'b000; cyc(); rst3 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          dat[i]  = {2'(i), seqn[i]};
          lst[i]  = 1'($urandom_range(0, 1));
        end
        in_valid3[i]       = pend[i];
        in_data3[i*8 +: 8] = dat[i];
        in_last3[i]        = lst[i];
      end
      out_ready3 = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_ov || out_ready3;
      found = 1'b0; g = 0;
      if (m_lock) begin
        g = m_lch; found = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          c = (m_ptr + k) % 3;
          if (!found && pend[c]) begin g = c; found = 1'b1; end
        end
      end
      exp_rdy = (can && found) ? 3'(1 << g) : 3'b000;
      n_checks++;
      if (in_ready3 !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready3, exp_rdy);
      end
      n_checks++;
      if (m_ov ? ({out_valid3, out_data3, out_sel3, out_last3} !== {1'b1, m_od, 2'(m_os), m_ol})
               : (out_valid3 !== 1'b0)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d l=%b, want v=%b d=%h s=%0d l=%b",
                 n, out_valid3, out_data3, out_sel3, out_last3, m_ov, m_od, m_os, m_ol);
      end
      acc = found && can && pend[g];
      if (acc) begin
        m_ov = 1'b1; m_od = dat[g]; m_os = g; m_ol = lst[g];
        if (lst[g]) begin m_ptr = (g + 1) % 3; m_lock = 1'b0; end
        else begin m_lock = 1'b1; m_lch = g; end
        pend[g] = 1'b0;
        seqn[g] = seqn[g] + 6'd1;
      end else if (out_ready3) begin
        m_ov = 1'b0;
      end
      cyc();
    end
    in_valid3 = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst4 = 1'b1; in_data4 = '0; in_valid4 = '0; in_last4 = '0; out_ready4 = 1'b1;
    rst3 = 1'b1; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
    test_reset();
    test_single();
    test_fairness_backpressure();
    test_packet_lock();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer. It is the sequential successor to the combinational mux4to1.
- Arbitrates between N_IN valid/ready input channels with a round-robin arbiter and forwards one beat per cycle through a registered output stage.
- Optional packet lock keeps the grant on one channel until its last beat.
- Used wherever several producers (e.g. attention heads, DMA readers) share one downstream datapath in the SoC.

Parameters:
- WIDTH, 8: data width per channel, in bits.
- N_IN, 4: number of input channels. Must be >= 2; need not be a power of two.
- LOCK_ON_LAST, 1: 1 = hold the grant until in_last is accepted; 0 = re-arbitrate after every beat.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_last  in  N_IN  per-channel end-of-packet marker.
- in_ready  out  N_IN  per-channel ready; combinational.
- out_data  out  WIDTH  registered output beat.
- out_last  out  1  registered last flag of the output beat.
- out_sel  out  $clog2(N_IN)  index of the source channel of the current output beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at the clock edge): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer ptr=0, lock=0, locked channel=0.
  - in_ready is all-zero while rst=1.
  - Reset mid-packet discards the lock and any held output beat.
- Output register:
  - Can load when out_valid=0 or (out_valid & out_ready).
  - While out_valid=1 & out_ready=0, out_data, out_last and out_sel hold stable.
- Arbitration, when not locked:
  - Grant the first channel with in_valid=1, searching ptr, ptr+1, ..., wrapping modulo N_IN (e.g. N_IN=3: 2 -> 0).
  - No valid input means no grant.
- Arbitration, when locked: grant only the locked channel, even if its in_valid=0; the block waits for it.
- Handshake:
  - in_ready[g] = can_load & grant[g]; all other bits are 0.
  - in_ready may depend on in_valid; there is no combinational path from in_ready to in_valid.
  - Beat accepted when in_valid[g] & in_ready[g]. Next edge: out_data = channel g data, out_last = in_last[g], out_sel = g, out_valid = 1.
  - Without an acceptance, out_valid clears if the held beat drained (out_ready=1), else holds.
- Latency and throughput: one cycle input-to-output; sustained one beat per cycle when out_ready=1.
- Pointer and lock update on accept from channel g:
  - If LOCK_ON_LAST=0 or in_last[g]=1: ptr <= (g+1) mod N_IN, lock <= 0.
  - Else: lock <= 1, locked channel <= g, ptr unchanged.
- Simultaneous drain and accept in the same cycle: legal. No bubble, no duplicate, no drop.
- Sources must hold data stable while valid & !ready; the block never drops or reorders beats within a channel.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1111, out_ready=1.
  -> out_valid=0, out_data=0x00, out_sel=0, in_ready=0000. First grant after release is ch0.
- Single channel: in_valid=0100, ch2 data=0x33, in_last=1, out_ready=1.
  -> in_ready=0100. Next cycle out_valid=1, out_data=0x33, out_sel=2, out_last=1.
- Fairness: in_valid=1111, in_last=1111, ch i data=0x11*(i+1), out_ready=1 for 8 cycles.
  -> out_data sequence 11,22,33,44,11,22,33,44 with no idle cycles.
- Backpressure: during the fairness run, hold out_ready=0 for 3 cycles while out_data=0x22.
  -> out_data stays 0x22 and in_ready=0000 for those cycles. After release, the next beat is 0x33; no loss or duplication.
- Packet lock (LOCK_ON_LAST=1): ch1 sends a 3-beat packet A1,A2,A3 (last on A3) with an idle cycle before A2. ch0 and ch2 stay valid throughout.
  -> Outputs A1,A2,A3 consecutive with out_sel=1; ch0 and ch2 are never granted during the packet. Then the ch2 beat follows (ptr=2).
- Reset mid-packet and non-power-of-two wrap:
  - N_IN=3: assert rst after A2 -> lock cleared, out_valid=0, next grant from ch0.
  - Then 200 random valid/last/out_ready cycles, checked against a scoreboard model of arbitration order and per-channel data order.
